// File: rtl/guess_checker_if.sv
// Signal bundle between the guess checker and its environment.
// The master side supplies the target and keypad data; the slave side is the checker.
interface guess_checker_if #(
    parameter int unsigned SCORE_W = 8
);
    logic [15:0]        target;
    logic               target_valid;
    logic [15:0]        value;
    logic               valueReady;
    logic               target_ready;
    logic               decoder_clr;
    logic               result_valid;
    logic               match;
    logic [2:0]         digits_correct;
    logic [SCORE_W-1:0] score;
    logic [1:0]         lives;
    logic               game_over;

    modport master (
        output target, target_valid, value, valueReady,
        input  target_ready, decoder_clr, result_valid, match,
               digits_correct, score, lives, game_over
    );

    modport slave (
        input  target, target_valid, value, valueReady,
        output target_ready, decoder_clr, result_valid, match,
               digits_correct, score, lives, game_over
    );
endinterface

// File: rtl/guess_checker.sv
// Keypad guessing game: latches a 4-digit BCD target and compares keypad guesses
// against it, tracking score and remaining lives until the game is over.
module guess_checker #(
    parameter int unsigned MAX_LIVES = 3,
    parameter int unsigned SCORE_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    guess_checker_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_DRAIN,
        S_WAIT_GUESS,
        S_COMPARE,
        S_OVER
    } state_e;

    localparam logic [1:0] LIVES_INIT = 2'(MAX_LIVES);

    state_e             state_q, state_d;
    logic [15:0]        target_q, target_d;
    logic [15:0]        guess_q, guess_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [1:0]         lives_q, lives_d;
    logic               match_q, match_d;
    logic [2:0]         dc_q, dc_d;
    logic               rv_q, rv_d;

    logic [3:0]         nib_eq;
    logic [2:0]         hits;

    // An all-ones guess nibble marks an unentered digit and never counts as a hit.
    always_comb begin
        nib_eq = '0;
        hits   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            nib_eq[i] = (guess_q[i*4 +: 4] == target_q[i*4 +: 4]) &&
                        (guess_q[i*4 +: 4] != 4'hF);
            hits      = hits + {2'b00, nib_eq[i]};
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        guess_d  = guess_q;
        score_d  = score_q;
        lives_d  = lives_q;
        match_d  = match_q;
        dc_d     = dc_q;
        rv_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.target_valid) begin
                    target_d = bus.target;
                    state_d  = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!bus.valueReady) begin
                    state_d = S_WAIT_GUESS;
                end
            end
            S_WAIT_GUESS: begin
                if (bus.valueReady) begin
                    guess_d = bus.value;
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                rv_d    = 1'b1;
                dc_d    = hits;
                match_d = (hits == 3'd4);
                if (hits == 3'd4) begin
                    if (score_q != '1) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                    state_d = S_IDLE;
                end else begin
                    lives_d = lives_q - 2'd1;
                    state_d = (lives_q == 2'd1) ? S_OVER : S_CLEAR;
                end
            end
            S_OVER: begin
                state_d = S_OVER;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            target_q <= '0;
            guess_q  <= '0;
            score_q  <= '0;
            lives_q  <= LIVES_INIT;
            match_q  <= 1'b0;
            dc_q     <= '0;
            rv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            guess_q  <= guess_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
            match_q  <= match_d;
            dc_q     <= dc_d;
            rv_q     <= rv_d;
        end
    end

    assign bus.target_ready   = (state_q == S_IDLE);
    assign bus.decoder_clr    = (state_q == S_CLEAR);
    assign bus.game_over      = (state_q == S_OVER);
    assign bus.result_valid   = rv_q;
    assign bus.match          = match_q;
    assign bus.digits_correct = dc_q;
    assign bus.score          = score_q;
    assign bus.lives          = lives_q;
endmodule

// File: tb/tb_guess_checker.sv
// Self-checking bench for guess_checker: vector table, directed corner sequences
// and randomized games checked against a round-level game model.
module tb_guess_checker;
    localparam int unsigned SW = 2;
    localparam int unsigned ML = 3;
    localparam int unsigned SCORE_MAX = (1 << SW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    guess_checker_if #(.SCORE_W(SW)) bus ();

    guess_checker #(.MAX_LIVES(ML), .SCORE_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       m;
        logic [2:0] dc;
        logic       clr;
        int         score;
        int         lives;
        logic       over;
        logic       tready;
    } res_t;

    typedef struct {
        logic [15:0] t;
        logic [15:0] g;
        logic        m;
        int          dc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.target_valid = 1'b0;
        bus.valueReady   = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_target(input logic [15:0] t);
        chk("target_ready_idle", bus.target_ready, 1);
        bus.target = t;
        bus.target_valid = 1'b1;
        tick();
        bus.target_valid = 1'b0;
        chk("clr_pulse_hi", bus.decoder_clr, 1);
        tick();
        chk("clr_pulse_lo", bus.decoder_clr, 0);
    endtask

    // Waits for the decoder drain, presents a guess, and captures the result cycle.
    task automatic send_guess(input logic [15:0] g, output res_t r);
        int lat;
        bus.valueReady = 1'b0;
        tick();
        tick();
        bus.value = g;
        bus.valueReady = 1'b1;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            lat++;
            if (bus.result_valid) break;
        end
        chk("result_latency", lat, 2);
        r.m      = bus.match;
        r.dc     = bus.digits_correct;
        r.clr    = bus.decoder_clr;
        r.score  = int'(bus.score);
        r.lives  = int'(bus.lives);
        r.over   = bus.game_over;
        r.tready = bus.target_ready;
        bus.valueReady = 1'b0;
        tick();
        chk("result_pulse_width", bus.result_valid, 0);
    endtask

    function automatic int digits(input logic [15:0] t, input logic [15:0] g);
        int c = 0;
        for (int i = 0; i < 4; i++) begin
            int tn = (t >> (4 * i)) & 15;
            int gn = (g >> (4 * i)) & 15;
            if (gn != 15 && gn == tn) c++;
        end
        return c;
    endfunction

    initial begin
        vec_t vt[7];
        res_t r;
        bit   seen;

        bus.target = '0;
        bus.value  = '0;
        bus.target_valid = 1'b0;
        bus.valueReady   = 1'b0;
        rst = 1'b1;
        tick();

        // Reset state
        do_reset();
        chk("rst_score", bus.score, 0);
        chk("rst_lives", bus.lives, ML);
        chk("rst_match", bus.match, 0);
        chk("rst_dc", bus.digits_correct, 0);
        chk("rst_rv", bus.result_valid, 0);
        chk("rst_clr", bus.decoder_clr, 0);
        chk("rst_over", bus.game_over, 0);
        chk("rst_tready", bus.target_ready, 1);

        // Single-round vectors from reset
        vt = '{
            '{16'h1234, 16'h1234, 1'b1, 4},
            '{16'h5678, 16'h5671, 1'b0, 3},
            '{16'h0000, 16'hFFFF, 1'b0, 0},
            '{16'hFFFF, 16'hFFFF, 1'b0, 0},
            '{16'h1200, 16'h1299, 1'b0, 2},
            '{16'h9087, 16'h9F87, 1'b0, 3},
            '{16'hABCD, 16'hABCD, 1'b1, 4}
        };
        for (int i = 0; i < 7; i++) begin
            do_reset();
            load_target(vt[i].t);
            send_guess(vt[i].g, r);
            chk("vec_match", r.m, vt[i].m);
            chk("vec_dc", r.dc, vt[i].dc);
            chk("vec_score", r.score, vt[i].m ? 1 : 0);
            chk("vec_lives", r.lives, vt[i].m ? ML : ML - 1);
            chk("vec_clr", r.clr, vt[i].m ? 0 : 1);
            chk("vec_tready", r.tready, vt[i].m ? 1 : 0);
        end

        // Partial miss then retry of the same target
        do_reset();
        load_target(16'h5678);
        send_guess(16'h5671, r);
        chk("miss_match", r.m, 0);
        chk("miss_dc", r.dc, 3);
        chk("miss_lives", r.lives, 2);
        chk("miss_clr", r.clr, 1);
        send_guess(16'h5678, r);
        chk("retry_match", r.m, 1);
        chk("retry_score", r.score, 1);
        chk("retry_lives", r.lives, 2);

        // Game over and frozen outputs
        do_reset();
        load_target(16'h0000);
        for (int i = 0; i < 3; i++) begin
            send_guess(16'hFFFF, r);
            chk("over_dc", r.dc, 0);
            chk("over_lives_step", r.lives, 2 - i);
            chk("over_flag_step", r.over, (i == 2) ? 1 : 0);
        end
        bus.value = 16'h0000;
        bus.valueReady = 1'b1;
        bus.target = 16'h1111;
        bus.target_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.result_valid || bus.decoder_clr || bus.target_ready) seen = 1'b1;
        end
        chk("over_no_activity", seen, 0);
        chk("over_hold_flag", bus.game_over, 1);
        chk("over_hold_lives", bus.lives, 0);
        chk("over_hold_score", bus.score, 0);
        chk("over_hold_dc", bus.digits_correct, 0);
        bus.valueReady = 1'b0;
        bus.target_valid = 1'b0;

        // Stale valueReady across CLEAR/DRAIN, target changes ignored
        do_reset();
        bus.value = 16'h4321;
        bus.valueReady = 1'b1;
        load_target(16'h4321);
        bus.target = 16'h9999;
        bus.target_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.result_valid) seen = 1'b1;
        end
        bus.target_valid = 1'b0;
        chk("stale_no_compare", seen, 0);
        send_guess(16'h4321, r);
        chk("stale_match", r.m, 1);
        chk("stale_dc", r.dc, 4);

        // Score saturation then reset during COMPARE
        do_reset();
        for (int i = 0; i < 4; i++) begin
            load_target(16'h2468 + 16'(i));
            send_guess(16'h2468 + 16'(i), r);
            chk("sat_score", r.score, (i < 2) ? i + 1 : SCORE_MAX);
        end
        load_target(16'h1357);
        bus.valueReady = 1'b0;
        tick();
        tick();
        bus.value = 16'h1357;
        bus.valueReady = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.valueReady = 1'b0;
        chk("rstcmp_rv", bus.result_valid, 0);
        chk("rstcmp_score", bus.score, 0);
        chk("rstcmp_lives", bus.lives, ML);
        chk("rstcmp_tready", bus.target_ready, 1);
        tick();
        chk("rstcmp_rv_late", bus.result_valid, 0);

        // Randomized games against the round-level model
        for (int game = 0; game < 8; game++) begin
            int  sc = 0;
            int  lv = ML;
            bit  over = 1'b0;
            do_reset();
            for (int rnd = 0; rnd < 6 && !over; rnd++) begin
                logic [15:0] t = 16'($urandom);
                load_target(t);
                for (int k = 0; k < 4; k++) begin
                    logic [15:0] g = t;
                    int  edc;
                    bit  em;
                    for (int n = 0; n < 4; n++)
                        if ($urandom_range(0, 2) == 0) g[4*n +: 4] = 4'($urandom_range(0, 15));
                    edc = digits(t, g);
                    em  = (edc == 4);
                    if (em) sc = (sc < SCORE_MAX) ? sc + 1 : sc;
                    else begin
                        lv--;
                        if (lv == 0) over = 1'b1;
                    end
                    send_guess(g, r);
                    chk("rnd_match", r.m, em);
                    chk("rnd_dc", r.dc, edc);
                    chk("rnd_score", r.score, sc);
                    chk("rnd_lives", r.lives, lv);
                    chk("rnd_over", r.over, over);
                    if (em || over) break;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
